if_pc_gen: RTL and testbench

- Parametrised program-counter generator for the IF stage; replaces the fixed PC+4 adder.
- Holds the PC register and steps by 4, or by 2 for compressed instructions when C_EXT=1.
- Handles stall, branch redirect and trap redirect with fixed priority, and traps misaligned branch targets.
- Drives the instruction-memory fetch address through a valid/ready handshake.

---
 rtl/if_pc_gen.sv | 95 +++++++++
 tb/tb_if_pc_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_gen.sv
// Program-counter generator for the IF stage. Holds the fetch PC and steps it by 4 (or 2 for
// compressed code). Applies trap and branch redirects, and turns misaligned branch targets into a trap.
module if_pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter bit              C_EXT        = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_i,
  input  logic            imem_ready_i,
  input  logic            insn_is_compressed_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_seq_o,
  output logic            pc_valid_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] badaddr_o
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FAULT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_badaddr;
  logic            r_pc_valid;
  logic            r_flush;
  logic            r_misalign;

  logic [XLEN-1:0] w_step;
  logic            w_misaligned;
  logic            w_accept;

  assign w_step        = (C_EXT && insn_is_compressed_i) ? XLEN'(2) : XLEN'(4);
  // Without compressed support, targets must be 4-byte aligned.
  assign w_misaligned  = C_EXT ? br_target_i[0] : (br_target_i[1:0] != 2'b00);
  assign w_accept      = r_pc_valid & imem_ready_i;
  assign pc_next_seq_o = r_pc + w_step;

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_badaddr  <= '0;
      r_pc_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_RUN;
          r_pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (trap_i) begin
            r_pc    <= TRAP_VECTOR;
            r_flush <= 1'b1;
          end else if (br_taken_i && !w_misaligned) begin
            r_pc    <= br_target_i;
            r_flush <= 1'b1;
          end else if (br_taken_i) begin
            r_state    <= ST_FAULT;
            r_badaddr  <= br_target_i;
            r_pc_valid <= 1'b0;
            r_misalign <= 1'b1;
          end else if (!stall_i && w_accept) begin
            r_pc <= pc_next_seq_o;
          end
        end
        ST_FAULT: begin
          // A fault always resolves to the trap vector on the following cycle.
          r_state    <= ST_RUN;
          r_pc       <= TRAP_VECTOR;
          r_pc_valid <= 1'b1;
          r_flush    <= 1'b1;
          r_misalign <= 1'b0;
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign pc_o       = r_pc;
  assign pc_valid_o = r_pc_valid;
  assign flush_o    = r_flush;
  assign misalign_o = r_misalign;
  assign badaddr_o  = r_badaddr;

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: compressed (C_EXT=1) and uncompressed (C_EXT=0) instances share the same
// stimulus. A behavioural model queues the expected state of each instance, which is compared on every cycle.
module tb_if_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall_i, br_taken_i, trap_i, imem_ready_i, insn_is_compressed_i;
  logic [31:0] br_target_i;

  logic [31:0] c_pc, c_nseq, c_bad, n_pc, n_nseq, n_bad;
  logic        c_valid, c_flush, c_mis, n_valid, n_flush, n_mis;

  always #5 clk = ~clk;

  if_pc_gen #(.C_EXT(1'b1)) dut_c (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .trap_i(trap_i), .imem_ready_i(imem_ready_i), .insn_is_compressed_i(insn_is_compressed_i),
    .pc_o(c_pc), .pc_next_seq_o(c_nseq), .pc_valid_o(c_valid), .flush_o(c_flush),
    .misalign_o(c_mis), .badaddr_o(c_bad)
  );

  if_pc_gen #(.C_EXT(1'b0)) dut_n (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .trap_i(trap_i), .imem_ready_i(imem_ready_i), .insn_is_compressed_i(insn_is_compressed_i),
    .pc_o(n_pc), .pc_next_seq_o(n_nseq), .pc_valid_o(n_valid), .flush_o(n_flush),
    .misalign_o(n_mis), .badaddr_o(n_bad)
  );

  // Model phases: 0 = boot, 1 = run, 2 = fault.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] bad;
    logic        valid;
    logic        flush;
    logic        mis;
    int          st;
  } mstate_t;

  typedef struct {
    mstate_t c;
    mstate_t n;
  } exp_pair_t;

  exp_pair_t sb[$];
  mstate_t   m_c, m_n;
  int        n_vec = 0;
  int        n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] step_of(input bit cext);
    return (cext && insn_is_compressed_i) ? 32'd2 : 32'd4;
  endfunction

  function automatic mstate_t model(input mstate_t s, input bit cext);
    mstate_t n;
    logic    bad_tgt;
    bad_tgt = cext ? br_target_i[0] : (br_target_i[1:0] != 2'b00);
    n       = s;
    n.flush = 1'b0;
    if (rst) begin
      n = '{pc: 32'h0, bad: 32'h0, valid: 1'b0, flush: 1'b0, mis: 1'b0, st: 0};
    end else if (s.st == 0) begin
      n.st    = 1;
      n.valid = 1'b1;
    end else if (s.st == 2 || trap_i) begin
      n = '{pc: 32'h100, bad: s.bad, valid: 1'b1, flush: 1'b1, mis: 1'b0, st: 1};
    end else if (br_taken_i && bad_tgt) begin
      n.st    = 2;
      n.bad   = br_target_i;
      n.valid = 1'b0;
      n.mis   = 1'b1;
    end else if (br_taken_i) begin
      n.pc    = br_target_i;
      n.flush = 1'b1;
    end else if (!stall_i && imem_ready_i) begin
      n.pc = s.pc + step_of(cext);
    end
    return n;
  endfunction

  task automatic tick();
    exp_pair_t e;
    m_c = model(m_c, 1'b1);
    m_n = model(m_n, 1'b0);
    e.c = m_c;
    e.n = m_n;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("c_pc", c_pc, e.c.pc);
    check("c_valid", 32'(c_valid), 32'(e.c.valid));
    check("c_flush", 32'(c_flush), 32'(e.c.flush));
    check("c_misalign", 32'(c_mis), 32'(e.c.mis));
    check("c_badaddr", c_bad, e.c.bad);
    check("c_next_seq", c_nseq, e.c.pc + step_of(1'b1));
    check("n_pc", n_pc, e.n.pc);
    check("n_valid", 32'(n_valid), 32'(e.n.valid));
    check("n_flush", 32'(n_flush), 32'(e.n.flush));
    check("n_misalign", 32'(n_mis), 32'(e.n.mis));
    check("n_badaddr", n_bad, e.n.bad);
    check("n_next_seq", n_nseq, e.n.pc + step_of(1'b0));
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    br_taken_i  = 1'b1;
    br_target_i = tgt;
    tick();
    br_taken_i  = 1'b0;
  endtask

  initial begin
    m_c = '{pc: 32'hx, bad: 32'hx, valid: 1'bx, flush: 1'bx, mis: 1'bx, st: 0};
    m_n = m_c;
    rst = 1'b1; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'h0;
    trap_i = 1'b0; imem_ready_i = 1'b0; insn_is_compressed_i = 1'b0;

    // Reset and boot, then sequential fetch by 4.
    repeat (2) tick();
    rst = 1'b0;
    check("boot_valid", 32'(c_valid), 32'd0);
    imem_ready_i = 1'b1;
    tick();
    check("run_valid", 32'(n_valid), 32'd1);
    check("run_pc0", n_pc, 32'h0);
    repeat (3) tick();
    check("seq_pc12", n_pc, 32'd12);

    // Compressed stepping on the C_EXT=1 instance; the other ignores the flag.
    branch_to(32'h10);
    insn_is_compressed_i = 1'b1; tick();
    check("cmp_0x12", c_pc, 32'h12);
    insn_is_compressed_i = 1'b0; tick();
    check("cmp_0x16", c_pc, 32'h16);
    insn_is_compressed_i = 1'b1; tick();
    check("cmp_0x18", c_pc, 32'h18);
    check("nocmp_0x1c", n_pc, 32'h1c);
    insn_is_compressed_i = 1'b0;

    // Stall then backpressure holds the PC.
    branch_to(32'h20);
    stall_i = 1'b1; repeat (3) tick();
    stall_i = 1'b0; imem_ready_i = 1'b0; repeat (2) tick();
    check("hold_0x20", c_pc, 32'h20);
    imem_ready_i = 1'b1; tick();
    check("adv_0x24", c_pc, 32'h24);

    // Redirects override stall; trap beats branch.
    stall_i = 1'b1;
    branch_to(32'h400);
    check("br_stall_pc", c_pc, 32'h400);
    check("br_flush", 32'(c_flush), 32'd1);
    tick();
    check("flush_drop", 32'(c_flush), 32'd0);
    trap_i = 1'b1; branch_to(32'h800); trap_i = 1'b0;
    check("trap_wins", n_pc, 32'h100);
    stall_i = 1'b0;

    // Misaligned targets.
    branch_to(32'h203);
    check("fault_mis", 32'(c_mis), 32'd1);
    check("fault_bad", c_bad, 32'h203);
    tick();
    check("fault_trap_pc", c_pc, 32'h100);
    branch_to(32'h202);
    check("c_ok_0x202", c_pc, 32'h202);
    check("n_fault_0x202", 32'(n_mis), 32'd1);
    tick();

    // Wrap, then reset during a fault.
    branch_to(32'hFFFF_FFFC);
    tick();
    check("wrap_zero", n_pc, 32'h0);
    branch_to(32'h203);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_in_fault", 32'(c_mis), 32'd0);
    repeat (3) tick();

    // Random mix, including trap and branch while faulted.
    for (int i = 0; i < 300; i++) begin
      rst                  = ($urandom_range(0, 49) == 0);
      stall_i              = ($urandom_range(0, 3) == 0);
      br_taken_i           = ($urandom_range(0, 4) == 0);
      trap_i               = ($urandom_range(0, 9) == 0);
      imem_ready_i         = ($urandom_range(0, 3) != 0);
      insn_is_compressed_i = 1'($urandom);
      br_target_i          = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
